// File: rtl/replacer_cnt_gen.sv
// Purpose : turns replacement distances into count bytes {extend, advance[6:0]} for the count FIFO.
// Latency : distance accepted at edge N gives its first cnt_wr after edge N+1; one byte per enabled cycle.
// Backpres: cnt_afull or ~clk_en freezes all state; registered outputs let the FIFO absorb 2 late writes.
//
// Ports:
//   clk, rst (async active-low)       clock / reset
//   clk_en                            global enable
//   dist_in/dist_valid/dist_last      distance stream in; dist_ready accepts it
//   cnt_afull                         count FIFO almost-full
//   cnt_out/cnt_wr                    count byte and write strobe
//   busy                              emitting bytes for a distance
//   frame_done/frame_bytes            end-of-frame pulse and byte total of last frame
module replacer_cnt_gen #(
    parameter int DIST_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              dist_valid,
    input  logic              dist_last,
    output logic              dist_ready,
    input  logic              cnt_afull,
    output logic [7:0]        cnt_out,
    output logic              cnt_wr,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_bytes
);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    localparam logic [DIST_W-1:0] MAX_ADV = DIST_W'(127);

    state_t            r_state;
    logic [DIST_W-1:0] r_rem;
    logic              r_last;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [7:0]        r_cnt_out;
    logic              r_cnt_wr;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_frame_bytes;

    logic              w_en;
    logic              w_fits;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_en      = clk_en & ~cnt_afull;
    // Split only while rem > 127: an exact multiple of 127 ends on 0xFF, not an extra 0x80.
    assign w_fits    = (r_rem <= MAX_ADV);
    assign w_cnt_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);

    // A new distance can be taken while the final byte of the current one is being decided.
    assign dist_ready = w_en & ((r_state == ST_IDLE) | ((r_state == ST_EMIT) & w_fits));

    assign cnt_out     = r_cnt_out;
    assign cnt_wr      = r_cnt_wr;
    assign frame_done  = r_frame_done;
    assign frame_bytes = r_frame_bytes;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_rem         <= '0;
            r_last        <= 1'b0;
            r_frame_cnt   <= '0;
            r_cnt_out     <= 8'h00;
            r_cnt_wr      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_bytes <= '0;
        end else begin
            // Strobes are single-cycle; cnt_out keeps its last value when idle or stalled.
            r_cnt_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (dist_valid) begin
                            r_rem   <= dist_in;
                            r_last  <= dist_last;
                            r_state <= ST_EMIT;
                        end
                    end
                    ST_EMIT: begin
                        r_cnt_wr <= 1'b1;
                        if (!w_fits) begin
                            // Non-extending full skip.
                            r_cnt_out   <= 8'h7F;
                            r_rem       <= r_rem - MAX_ADV;
                            r_frame_cnt <= w_cnt_inc;
                        end else begin
                            r_cnt_out <= {1'b1, r_rem[6:0]};
                            if (r_last) begin
                                r_frame_bytes <= w_cnt_inc;
                                r_frame_done  <= 1'b1;
                                r_frame_cnt   <= '0;
                            end else begin
                                r_frame_cnt <= w_cnt_inc;
                            end
                            if (dist_valid) begin
                                // Back-to-back: last flag belongs to the newly loaded distance only.
                                r_rem  <= dist_in;
                                r_last <= dist_last;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_replacer_cnt_gen.sv
module tb_replacer_cnt_gen;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [15:0] dist_in;
    logic        dist_valid;
    logic        dist_last;
    logic        dist_ready;
    logic        cnt_afull;
    logic [7:0]  cnt_out;
    logic        cnt_wr;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_bytes;

    replacer_cnt_gen #(.DIST_W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .dist_in     (dist_in),
        .dist_valid  (dist_valid),
        .dist_last   (dist_last),
        .dist_ready  (dist_ready),
        .cnt_afull   (cnt_afull),
        .cnt_out     (cnt_out),
        .cnt_wr      (cnt_wr),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_bytes (frame_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int send_wait = 0;

    logic [7:0] q_byte[$];
    logic       q_fd[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every written byte away from the edge.
    always @(posedge clk) begin
        #1;
        if (cnt_wr === 1'b1) begin
            q_byte.push_back(cnt_out);
            q_fd.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_byte.delete();
        q_fd.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        dist_valid = 1'b0;
        dist_last  = 1'b0;
        dist_in    = 16'd0;
        cnt_afull  = 1'b0;
        clk_en     = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_cnt_wr",      32'(cnt_wr),      32'd0);
        check_val("rst_cnt_out",     32'(cnt_out),     32'd0);
        check_val("rst_frame_done",  32'(frame_done),  32'd0);
        check_val("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        check_val("rst_busy",        32'(busy),        32'd0);
        rst = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        dist_in    = d;
        dist_last  = l;
        dist_valid = 1'b1;
        while (dist_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_ready", 32'(dist_ready), 32'd1);
        send_wait = n;
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        dist_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Compares captured bytes; exp_fd=1 means exactly one frame_done, on the final byte.
    task automatic check_bytes(input string tag, input int n,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic exp_fd);
        logic [7:0] e[4];
        int pulses;
        e = '{b0, b1, b2, b3};
        pulses = 0;
        check_val({tag, "_count"}, 32'(q_byte.size()), 32'(n));
        for (int i = 0; i < n && i < 4; i++) begin
            if (i < q_byte.size())
                check_val($sformatf("%s_b%0d", tag, i), 32'(q_byte[i]), 32'(e[i]));
        end
        foreach (q_fd[i]) if (q_fd[i]) pulses++;
        check_val({tag, "_fd_pulses"}, 32'(pulses), 32'(exp_fd));
        if (q_fd.size() > 0)
            check_val({tag, "_fd_last"}, 32'(q_fd[q_fd.size()-1]), 32'(exp_fd));
    endtask

    initial begin
        int a1;
        int n;
        rst = 1'b1; clk_en = 1'b1; cnt_afull = 1'b0;
        dist_valid = 1'b0; dist_last = 1'b0; dist_in = 16'd0;

        // 1: single short distance
        do_reset();
        send(16'd5, 1'b0);
        drain();
        check_bytes("t1", 1, 8'h85, 8'h00, 8'h00, 8'h00, 1'b0);
        if (q_cyc.size() > 0) check_val("t1_latency", 32'(q_cyc[0] - acc_cyc), 32'd1);
        check_val("t1_frame_bytes", 32'(frame_bytes), 32'd0);

        // 2: zero, exact 127, just over 127
        do_reset();
        send(16'd0, 1'b0);
        send(16'd127, 1'b0);
        send(16'd128, 1'b0);
        drain();
        check_bytes("t2", 4, 8'h80, 8'hFF, 8'h7F, 8'h81, 1'b0);

        // 3: long distance closing a frame
        do_reset();
        send(16'd300, 1'b1);
        drain();
        check_bytes("t3", 3, 8'h7F, 8'h7F, 8'hAE, 8'h00, 1'b1);
        if (q_cyc.size() == 3) check_val("t3_consec", 32'(q_cyc[2] - q_cyc[0]), 32'd2);
        check_val("t3_frame_bytes", 32'(frame_bytes), 32'd3);

        // 4: back-to-back distances
        do_reset();
        send(16'd3, 1'b0);
        a1 = acc_cyc;
        send(16'd4, 1'b1);
        check_val("t4_no_wait", 32'(send_wait), 32'd0);
        check_val("t4_accept_gap", 32'(acc_cyc - a1), 32'd1);
        drain();
        check_bytes("t4", 2, 8'h83, 8'h84, 8'h00, 8'h00, 1'b1);
        if (q_cyc.size() == 2) check_val("t4_adjacent", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
        check_val("t4_frame_bytes", 32'(frame_bytes), 32'd2);

        // 5: stall via cnt_afull, then via clk_en
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            send(16'd400, 1'b1);
            @(posedge clk); #1;                  // first byte written here
            @(negedge clk);
            if (mode == 0) cnt_afull = 1'b1; else clk_en = 1'b0;
            repeat (5) @(negedge clk);
            check_val($sformatf("t5m%0d_stalled_count", mode), 32'(q_byte.size()), 32'd1);
            cnt_afull = 1'b0;
            clk_en    = 1'b1;
            drain();
            check_bytes($sformatf("t5m%0d", mode), 4, 8'h7F, 8'h7F, 8'h7F, 8'h93, 1'b1);
            if (q_cyc.size() == 4) check_val($sformatf("t5m%0d_gap", mode), 32'(q_cyc[1] - q_cyc[0]), 32'd6);
            check_val($sformatf("t5m%0d_frame_bytes", mode), 32'(frame_bytes), 32'd4);
        end

        // 6: reset in the middle of a long distance
        do_reset();
        send(16'd1000, 1'b0);
        n = 0;
        while (q_byte.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_two_bytes", 32'(q_byte.size()), 32'd2);
        rst = 1'b0;
        #1;
        check_val("t6_async_cnt_wr",  32'(cnt_wr),  32'd0);
        check_val("t6_async_cnt_out", 32'(cnt_out), 32'd0);
        check_val("t6_async_busy",    32'(busy),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_val("t6_no_more_bytes", 32'(q_byte.size()), 32'd2);
        check_val("t6_idle_after", 32'(busy), 32'd0);
        clear_q();
        send(16'd1, 1'b0);
        drain();
        check_bytes("t6", 1, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errs);
        $fatal(1);
    end

endmodule
